// File: rtl/fractal_sync_pkg.sv
// Shared request/response beat formats for the fractal sync ingress path,
// plus the round-robin pick used by the port arbiter.
package fractal_sync_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned AGGR_W    = 4;
  localparam int unsigned MAX_PORTS = 32;

  typedef struct packed {
    logic              sync;
    logic [AGGR_W-1:0] aggr;
    logic [ID_W-1:0]   id;
  } fsync_req_t;

  typedef struct packed {
    logic            wake;
    logic            error;
    logic [ID_W-1:0] id;
  } fsync_rsp_t;

  // First set bit of valid at or after start, wrapping at n; returns start if none.
  function automatic int unsigned rr_next(input logic [MAX_PORTS-1:0] valid,
                                          input int unsigned          n,
                                          input int unsigned          start);
    int unsigned idx;
    logic        found;
    rr_next = start;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      idx = (start + k) % n;
      if (!found && (k < n) && valid[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fractal_sync_fifo.sv
// Per-port request buffer; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module fractal_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; full/empty come from pre-cycle pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/fractal_sync_rx_arbiter_chk.sv
// Simulation-side checks on the node response interface.
module fractal_sync_rx_arbiter_chk #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned PORT_W  = 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              rsp_wake,
  input logic [PORT_W-1:0] rsp_port
);

  // Node responses must address an existing port; others are dropped by the router.
  a_rsp_port_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_wake |-> (32'(rsp_port) < N_PORTS));

endmodule

// File: rtl/fractal_sync_rx_arbiter.sv
// Node ingress: buffers each pipeline port, round-robin arbitrates the heads
// toward the node, and routes wake / overflow-error responses back.
module fractal_sync_rx_arbiter
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_req_t = fractal_sync_pkg::fsync_req_t,
  parameter type         fsync_rsp_t = fractal_sync_pkg::fsync_rsp_t,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PORT_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  fsync_req_t        req_i [N_PORTS],
  output fsync_rsp_t        rsp_o [N_PORTS],
  output fsync_req_t        req_o,
  output logic [PORT_W-1:0] req_port_o,
  input  logic              req_ready_i,
  input  fsync_rsp_t        rsp_i,
  input  logic [PORT_W-1:0] rsp_port_i
);

  logic [N_PORTS-1:0]   push, pop, full, empty, overflow, node_hit, emit;
  fsync_req_t           head [N_PORTS];
  fsync_rsp_t           err_rsp [N_PORTS];
  logic [MAX_PORTS-1:0] nonempty;
  logic [PORT_W-1:0]    rr_ptr, grant, lock_port;
  logic                 locked, handshake;
  logic [N_PORTS-1:0]   err_pend;
  logic [ID_W-1:0]      err_id [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign push[p]     = req_i[p].sync & ~full[p];
    assign overflow[p] = req_i[p].sync & full[p];

    fractal_sync_fifo #(
      .T     (fsync_req_t),
      .DEPTH (FIFO_DEPTH)
    ) i_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (push[p]),
      .wdata (req_i[p]),
      .pop   (pop[p]),
      .rdata (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
  end

  // Grant selection; a stalled grant is held so req_o stays stable.
  always_comb begin
    nonempty = '0;
    nonempty[N_PORTS-1:0] = ~empty;
    if (locked) begin
      grant = lock_port;
    end else begin
      grant = PORT_W'(rr_next(nonempty, N_PORTS, 32'(rr_ptr)));
    end
    req_o      = '0;
    req_port_o = '0;
    if (!empty[grant]) begin
      req_o      = head[grant];
      req_port_o = grant;
    end else begin
      req_o      = '0;
      req_port_o = '0;
    end
    handshake = req_o.sync & req_ready_i;
    pop = '0;
    if (handshake) begin
      pop[grant] = 1'b1;
    end else begin
      pop = '0;
    end
  end

  // Round-robin pointer and grant lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr    <= '0;
      locked    <= 1'b0;
      lock_port <= '0;
    end else begin
      locked    <= req_o.sync & ~req_ready_i;
      lock_port <= grant;
      if (handshake) begin
        rr_ptr <= (grant == PORT_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Per-port response sources; a node wake defers a pending error by a cycle.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      node_hit[p]      = rsp_i.wake && (32'(rsp_port_i) == 32'(p));
      emit[p]          = err_pend[p] & ~node_hit[p];
      err_rsp[p]       = '0;
      err_rsp[p].error = 1'b1;
      err_rsp[p].id    = err_id[p];
    end
  end

  // Registered response mux and sticky overflow-error capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_pend <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_o[p]  <= '0;
        err_id[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (node_hit[p]) begin
          rsp_o[p] <= rsp_i;
        end else if (err_pend[p]) begin
          rsp_o[p] <= err_rsp[p];
        end else begin
          rsp_o[p] <= '0;
        end
        if (overflow[p] && (!err_pend[p] || emit[p])) begin
          err_pend[p] <= 1'b1;
          err_id[p]   <= req_i[p].id;
        end else if (emit[p]) begin
          err_pend[p] <= 1'b0;
        end
      end
    end
  end

  fractal_sync_rx_arbiter_chk #(
    .N_PORTS(N_PORTS),
    .PORT_W (PORT_W)
  ) i_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rsp_wake(rsp_i.wake),
    .rsp_port(rsp_port_i)
  );

endmodule

// File: tb/tb_fractal_sync_rx_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, negedge
// monitors pop and compare whenever the DUT presents a beat.
module tb_fractal_sync_rx_arbiter;
  import fractal_sync_pkg::*;

  localparam int NP = 2;
  localparam int PW = 1;

  logic              clk = 1'b0;
  logic              rst_ni;
  fsync_req_t        req_i [NP];
  fsync_rsp_t        rsp_o [NP];
  fsync_req_t        req_o;
  logic [PW-1:0]     req_port_o;
  logic              req_ready_i;
  fsync_rsp_t        rsp_i;
  logic [PW-1:0]     rsp_port_i;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0]   exp_req_port [$];
  logic [ID_W-1:0] exp_req_id   [$];
  logic [PW-1:0]   exp_rsp_port [$];
  fsync_rsp_t      exp_rsp      [$];

  always #5 clk = ~clk;

  fractal_sync_rx_arbiter #(
    .N_PORTS   (NP),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .rsp_o      (rsp_o),
    .req_o      (req_o),
    .req_port_o (req_port_o),
    .req_ready_i(req_ready_i),
    .rsp_i      (rsp_i),
    .rsp_port_i (rsp_port_i)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input int p, input int id);
    exp_req_port.push_back(PW'(p));
    exp_req_id.push_back(ID_W'(id));
  endtask

  task automatic exp_rs(input int p, input logic wake, input logic err, input int id);
    exp_rsp_port.push_back(PW'(p));
    exp_rsp.push_back({wake, err, ID_W'(id)});
  endtask

  task automatic beat(input int p, input int id);
    req_i[p] = {1'b1, 4'd0, ID_W'(id)};
  endtask

  task automatic idle_reqs();
    req_i[0] = '0;
    req_i[1] = '0;
  endtask

  // Request monitor: a handshake completes at the coming posedge.
  always @(negedge clk) begin
    if (rst_ni && req_o.sync && req_ready_i) begin
      if (exp_req_id.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got port=%0d id=%0d want none", req_port_o, req_o.id);
      end else begin
        chk("req_port", 32'(req_port_o), 32'(exp_req_port.pop_front()));
        chk("req_id", 32'(req_o.id), 32'(exp_req_id.pop_front()));
      end
    end
  end

  // Response monitor: any wake/error beat on any port must be expected next.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp_o[p].wake || rsp_o[p].error) begin
          if (exp_rsp.size() == 0 || int'(exp_rsp_port[0]) != p) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: port=%0d got 0x%0h want none", p, rsp_o[p]);
          end else begin
            void'(exp_rsp_port.pop_front());
            chk($sformatf("rsp_port%0d", p), 32'(rsp_o[p]), 32'(exp_rsp.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst_ni      = 1'b0;
    req_ready_i = 1'b0;
    rsp_i       = '0;
    rsp_port_i  = '0;
    idle_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_o", 32'(req_o), 32'd0);
    chk("rst_req_port", 32'(req_port_o), 32'd0);
    chk("rst_rsp0", 32'(rsp_o[0]), 32'd0);
    chk("rst_rsp1", 32'(rsp_o[1]), 32'd0);
    step();
    rst_ni = 1'b1;

    // Single request and its wake response
    req_ready_i = 1'b1;
    exp_req(1, 5);
    beat(1, 5);
    step();
    idle_reqs();
    step();
    exp_rs(1, 1'b1, 1'b0, 5);
    rsp_i      = {1'b1, 1'b0, 8'd5};
    rsp_port_i = 1'b1;
    step();
    rsp_i = '0;
    repeat (2) step();

    // Fairness: expected grant order 0,1,0,1,0,1
    for (int i = 0; i < 3; i++) begin
      exp_req(0, 10 + i);
      exp_req(1, 20 + i);
    end
    for (int i = 0; i < 3; i++) begin
      beat(0, 10 + i);
      beat(1, 20 + i);
      step();
    end
    idle_reqs();
    repeat (8) step();

    // Backpressure: port 1 granted alone, then port 0 fills; grant must hold
    req_ready_i = 1'b0;
    beat(1, 40);
    step();
    idle_reqs();
    beat(0, 30);
    step();
    idle_reqs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_port", 32'(req_port_o), 32'd1);
      chk("bp_id", 32'(req_o.id), 32'd40);
      step();
    end
    exp_req(1, 40);
    exp_req(0, 30);
    req_ready_i = 1'b1;
    repeat (4) step();

    // Overflow on port 0; id 6 collides with a node wake, error stays sticky on id 5
    req_ready_i = 1'b0;
    for (int id = 1; id <= 5; id++) begin
      beat(0, id);
      step();
    end
    exp_rs(0, 1'b1, 1'b0, 99);
    exp_rs(0, 1'b0, 1'b1, 5);
    beat(0, 6);
    rsp_i      = {1'b1, 1'b0, 8'd99};
    rsp_port_i = 1'b0;
    step();
    idle_reqs();
    rsp_i = '0;
    repeat (3) step();
    for (int id = 1; id <= 4; id++) exp_req(0, id);
    req_ready_i = 1'b1;
    repeat (6) step();

    // Mid-operation reset with queued beats and a pending error
    req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(0, 60 + i);
      if (i < 3) beat(1, 50 + i);
      else req_i[1] = '0;
      step();
    end
    idle_reqs();
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mrst_req_o", 32'(req_o), 32'd0);
    chk("mrst_req_port", 32'(req_port_o), 32'd0);
    chk("mrst_rsp0", 32'(rsp_o[0]), 32'd0);
    chk("mrst_rsp1", 32'(rsp_o[1]), 32'd0);
    step();
    rst_ni      = 1'b1;
    req_ready_i = 1'b1;
    repeat (6) step();
    exp_req(0, 77);
    beat(0, 77);
    step();
    idle_reqs();
    repeat (3) step();

    for (int k = 0; k < 50; k++) begin
      if (exp_req_id.size() == 0 && exp_rsp.size() == 0) break;
      step();
    end
    chk("pending_expectations", 32'(exp_req_id.size() + exp_rsp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
